alu_decode: RTL and testbench
=============================

Name: alu_decode

Overview:
- Registered decode stage that drives the ALU control interface.
- Takes a fetched RV32I instruction word and PC, and produces a one-cycle-latency bundle: ALU controls, operand selects, immediate, register indices and branch info.
- Sits between fetch and the ALU/register-file read; uses a valid/ready handshake in both directions plus a flush.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on o_pc while in reset.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  stage can accept
- i_insn  input  32  instruction word
- i_pc  input  32  instruction address
- i_flush  input  1  discard held and incoming instruction
- o_valid  output  1  decoded bundle valid
- i_ready  input  1  downstream accepts bundle
- o_pc  output  32  registered PC
- o_sub  output  1  ALU subtract; also selects arithmetic right shift
- o_bool_op  output  2  00 xor, 01 zero, 10 or, 11 and
- o_op_sel  output  4  one-hot result select: [0] add, [1] slt, [2] bool, [3] shift
- o_shift_dir  output  1  1 = right
- o_cmp_sig  output  1  signed compare
- o_a_sel  output  2  operand A: 00 rs1, 01 pc, 10 zero
- o_b_sel  output  1  operand B: 0 rs2, 1 imm
- o_imm  output  32  sign-extended immediate
- o_rs1, o_rs2, o_rd  output  5 each  register indices
- o_rd_wen  output  1  register writeback enable
- o_branch  output  1  conditional branch
- o_jump  output  1  JAL/JALR
- o_br_cond  output  3  funct3 of branch
- o_mem_rd, o_mem_wr  output  1 each  load/store
- o_illegal  output  1  unsupported encoding

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: o_valid=0, o_pc=RESET_PC, every other output 0.
- Handshake:
  - o_ready = ~o_valid | i_ready (combinational).
  - Accept when i_valid & o_ready; the decoded bundle appears registered on the next edge with o_valid=1 (latency 1).
  - If i_ready & ~(i_valid & o_ready), o_valid goes to 0.
  - While o_valid & ~i_ready, all outputs hold stable.
- Flush:
  - i_flush=1 forces o_valid=0 on the next edge.
  - An input handshake in the same cycle is dropped.
  - Flush has priority over accept; reset has priority over all.
- Opcode decode:
  - OP/OP-IMM: funct3 000 → add (sub = funct7[5], OP only); 010 slt cmp_sig=1 sub=1; 011 sltu cmp_sig=0 sub=1; 100 xor; 110 or; 111 and; 001 sll dir0; 101 srl/sra dir1, sub = funct7[5].
  - OP-IMM b_sel=1; shift-imm o_imm = {27'b0, shamt}.
  - LUI: a_sel=10, b_sel=1, add, imm = {insn[31:12], 12'b0}.
  - AUIPC: a_sel=01, b_sel=1, add.
  - JAL: a_sel=01, b_sel=1, add, J-imm, jump=1, rd_wen=1.
  - JALR: a_sel=00, b_sel=1, I-imm, jump=1, rd_wen=1.
  - BRANCH: a_sel=00, b_sel=0, add with sub=1, cmp_sig=1 for funct3 0xx/10x, 0 for 11x; B-imm; branch=1; rd_wen=0.
  - LOAD: add, b_sel=1, I-imm, mem_rd=1, rd_wen=1.
  - STORE: add, b_sel=1, S-imm, mem_wr=1, rd_wen=0.
- Illegal (o_illegal=1; rd_wen, branch, jump, mem_rd, mem_wr forced 0):
  - Unknown opcode.
  - OP funct7 not 0000000/0100000.
  - OP funct7=0100000 with funct3 ∉ {000,101}.
  - OP-IMM shift with insn[31:25] invalid.
  - BRANCH funct3 010/011.
  - JALR funct3≠000.
- Illegal instructions still complete the handshake.
- rd=x0 forces o_rd_wen=0.
- Unused o_op_sel bits are 0; exactly one bit is set for legal instructions.

Test Plan:
- ADDI x1,x0,5 (0x00500093), i_ready=1 → next cycle o_valid=1, op_sel=0001, sub=0, b_sel=1, imm=5, rd=1, rd_wen=1.
- SRAI x2,x1,3 (0x4030D113) → op_sel=1000, shift_dir=1, sub=1, imm=3, rs1=1, illegal=0.
- BLTU x1,x2,-4 (0xFE20EEE3) → branch=1, br_cond=110, sub=1, cmp_sig=0, imm=0xFFFFFFFC, rd_wen=0; LUI x5,0x12345 (0x123452B7) → a_sel=10, imm=0x12345000.
- Stall: o_valid=1, i_ready=0 for 3 cycles with i_valid=1 → o_ready=0 and outputs unchanged; raise i_ready → next instruction appears the following cycle, none lost or duplicated.
- Illegal 0xFFFFFFFF and ADDI x0,x0,1 → illegal=1 / rd_wen=0 respectively; both produce o_valid=1 for one transfer.
- i_flush during stall with i_valid=1 → o_valid=0 next cycle, incoming instruction discarded; i_rst mid-stream → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/alu_decode.sv
// RV32I decode stage: registers ALU controls, operand selects, immediate,
// register indices and branch/memory info behind a valid/ready handshake.
module alu_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_insn,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic        o_sub,
    output logic [1:0]  o_bool_op,
    output logic [3:0]  o_op_sel,
    output logic        o_shift_dir,
    output logic        o_cmp_sig,
    output logic [1:0]  o_a_sel,
    output logic        o_b_sel,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic        o_branch,
    output logic        o_jump,
    output logic [2:0]  o_br_cond,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_illegal
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011
    } opcode_e;

    typedef struct packed {
        logic        sub;
        logic [1:0]  bool_op;
        logic [3:0]  op_sel;
        logic        shift_dir;
        logic        cmp_sig;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        branch;
        logic        jump;
        logic [2:0]  br_cond;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } bundle_t;

    bundle_t     dec;
    bundle_t     bundle_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        accept;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        is_alu, is_op, legal;

    always_comb begin
        funct3 = i_insn[14:12];
        funct7 = i_insn[31:25];
        imm_i  = {{20{i_insn[31]}}, i_insn[31:20]};
        imm_s  = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
        imm_b  = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
        imm_u  = {i_insn[31:12], 12'b0};
        imm_j  = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
        imm_sh = {27'b0, i_insn[24:20]};

        dec     = '0;
        dec.rs1 = i_insn[19:15];
        dec.rs2 = i_insn[24:20];
        dec.rd  = i_insn[11:7];
        is_alu  = 1'b0;
        is_op   = 1'b0;
        legal   = 1'b1;

        case (opcode_e'(i_insn[6:0]))
            OPC_OP: begin
                is_alu     = 1'b1;
                is_op      = 1'b1;
                dec.rd_wen = 1'b1;
                legal      = (funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                is_alu     = 1'b1;
                dec.b_sel  = 1'b1;
                dec.rd_wen = 1'b1;
                dec.imm    = imm_i;
                if (funct3 == 3'b001) begin
                    dec.imm = imm_sh;
                    legal   = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.imm = imm_sh;
                    legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                dec.op_sel = 4'b0001;
                dec.a_sel  = 2'b10;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.rd_wen = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_sel = 4'b0001;
                dec.a_sel  = 2'b01;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.rd_wen = 1'b1;
            end
            OPC_JAL: begin
                dec.op_sel = 4'b0001;
                dec.a_sel  = 2'b01;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_j;
                dec.jump   = 1'b1;
                dec.rd_wen = 1'b1;
            end
            OPC_JALR: begin
                dec.op_sel = 4'b0001;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.jump   = 1'b1;
                dec.rd_wen = 1'b1;
                legal      = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.op_sel  = 4'b0001;
                dec.sub     = 1'b1;
                dec.cmp_sig = ~(funct3[2] & funct3[1]);
                dec.imm     = imm_b;
                dec.branch  = 1'b1;
                dec.br_cond = funct3;
                legal       = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec.op_sel = 4'b0001;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.mem_rd = 1'b1;
                dec.rd_wen = 1'b1;
            end
            OPC_STORE: begin
                dec.op_sel = 4'b0001;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_s;
                dec.mem_wr = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (is_alu) begin
            case (funct3)
                3'b000: begin
                    dec.op_sel = 4'b0001;
                    dec.sub    = is_op & funct7[5];
                end
                3'b010: begin
                    dec.op_sel  = 4'b0010;
                    dec.cmp_sig = 1'b1;
                    dec.sub     = 1'b1;
                end
                3'b011: begin
                    dec.op_sel = 4'b0010;
                    dec.sub    = 1'b1;
                end
                3'b100: begin
                    dec.op_sel  = 4'b0100;
                    dec.bool_op = 2'b00;
                end
                3'b110: begin
                    dec.op_sel  = 4'b0100;
                    dec.bool_op = 2'b10;
                end
                3'b111: begin
                    dec.op_sel  = 4'b0100;
                    dec.bool_op = 2'b11;
                end
                3'b001: dec.op_sel = 4'b1000;
                default: begin
                    dec.op_sel    = 4'b1000;
                    dec.shift_dir = 1'b1;
                    dec.sub       = funct7[5];
                end
            endcase
        end

        // Illegal words still flow downstream, but with every side effect suppressed.
        if (!legal) begin
            dec.illegal = 1'b1;
            dec.rd_wen  = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.rd_wen = 1'b0;
        end
    end

    assign o_ready = ~valid_q | i_ready;
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            pc_q     <= RESET_PC;
            bundle_q <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            pc_q     <= i_pc;
            bundle_q <= dec;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_sub       = bundle_q.sub;
    assign o_bool_op   = bundle_q.bool_op;
    assign o_op_sel    = bundle_q.op_sel;
    assign o_shift_dir = bundle_q.shift_dir;
    assign o_cmp_sig   = bundle_q.cmp_sig;
    assign o_a_sel     = bundle_q.a_sel;
    assign o_b_sel     = bundle_q.b_sel;
    assign o_imm       = bundle_q.imm;
    assign o_rs1       = bundle_q.rs1;
    assign o_rs2       = bundle_q.rs2;
    assign o_rd        = bundle_q.rd;
    assign o_rd_wen    = bundle_q.rd_wen;
    assign o_branch    = bundle_q.branch;
    assign o_jump      = bundle_q.jump;
    assign o_br_cond   = bundle_q.br_cond;
    assign o_mem_rd    = bundle_q.mem_rd;
    assign o_mem_wr    = bundle_q.mem_wr;
    assign o_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Bench for alu_decode: directed vector table, handshake corner sequences,
// and randomized traffic checked against an arithmetic decode model.
module tb_alu_decode;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_flush, i_ready;
    logic [31:0] i_insn, i_pc;
    logic        o_ready, o_valid;
    logic [31:0] o_pc, o_imm;
    logic        o_sub, o_shift_dir, o_cmp_sig, o_b_sel;
    logic [1:0]  o_bool_op, o_a_sel;
    logic [3:0]  o_op_sel;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic        o_rd_wen, o_branch, o_jump, o_mem_rd, o_mem_wr, o_illegal;
    logic [2:0]  o_br_cond;

    always #5 clk = ~clk;

    alu_decode #(.RESET_PC(RST_PC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_insn(i_insn), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_sub(o_sub), .o_bool_op(o_bool_op),
        .o_op_sel(o_op_sel), .o_shift_dir(o_shift_dir), .o_cmp_sig(o_cmp_sig),
        .o_a_sel(o_a_sel), .o_b_sel(o_b_sel), .o_imm(o_imm), .o_rs1(o_rs1),
        .o_rs2(o_rs2), .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_branch(o_branch),
        .o_jump(o_jump), .o_br_cond(o_br_cond), .o_mem_rd(o_mem_rd),
        .o_mem_wr(o_mem_wr), .o_illegal(o_illegal)
    );

    typedef struct packed {
        logic        illegal;
        logic [3:0]  op_sel;
        logic        sub;
        logic [1:0]  bool_op;
        logic        shift_dir;
        logic        cmp_sig;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        branch;
        logic        jump;
        logic [2:0]  br_cond;
        logic        mem_rd;
        logic        mem_wr;
    } exp_t;

    typedef struct {
        logic [31:0] insn;
        exp_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected stage state: what the output register should hold.
    bit          m_valid = 1'b0;
    exp_t        m_exp   = '0;
    logic [31:0] m_pc    = RST_PC;
    bit          m_full  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         ii, bi, ji;
        bit         ok, alu, is_op;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        ii  = $signed(w) >>> 20;
        bi  = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        ji  = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        e = '0;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        ok = 1'b1; alu = 1'b0; is_op = 1'b0;
        case (opc)
            7'h33: begin
                alu = 1'b1; is_op = 1'b1; e.rd_wen = 1'b1;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h13: begin
                alu = 1'b1; e.b_sel = 1'b1; e.rd_wen = 1'b1; e.imm = ii;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = 32'(w[24:20]);
                    ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                end
            end
            7'h37: begin e.op_sel = 1; e.a_sel = 2; e.b_sel = 1; e.imm = w & 32'hFFFF_F000; e.rd_wen = 1; end
            7'h17: begin e.op_sel = 1; e.a_sel = 1; e.b_sel = 1; e.imm = w & 32'hFFFF_F000; e.rd_wen = 1; end
            7'h6F: begin e.op_sel = 1; e.a_sel = 1; e.b_sel = 1; e.imm = ji; e.jump = 1; e.rd_wen = 1; end
            7'h67: begin e.op_sel = 1; e.b_sel = 1; e.imm = ii; e.jump = 1; e.rd_wen = 1; ok = (f3 == 0); end
            7'h63: begin
                e.op_sel = 1; e.sub = 1; e.branch = 1; e.br_cond = f3; e.imm = bi;
                e.cmp_sig = (f3 != 3'd6 && f3 != 3'd7);
                ok = (f3 != 3'd2 && f3 != 3'd3);
            end
            7'h03: begin e.op_sel = 1; e.b_sel = 1; e.imm = ii; e.mem_rd = 1; e.rd_wen = 1; end
            7'h23: begin e.op_sel = 1; e.b_sel = 1; e.imm = (ii & ~32'h1F) | 32'(w[11:7]); e.mem_wr = 1; end
            default: ok = 1'b0;
        endcase
        if (alu) begin
            case (f3)
                3'd0: begin e.op_sel = 4'b0001; e.sub = is_op && f7[5]; end
                3'd1: e.op_sel = 4'b1000;
                3'd2: begin e.op_sel = 4'b0010; e.cmp_sig = 1; e.sub = 1; end
                3'd3: begin e.op_sel = 4'b0010; e.sub = 1; end
                3'd4: begin e.op_sel = 4'b0100; e.bool_op = 2'b00; end
                3'd5: begin e.op_sel = 4'b1000; e.shift_dir = 1; e.sub = f7[5]; end
                3'd6: begin e.op_sel = 4'b0100; e.bool_op = 2'b10; end
                default: begin e.op_sel = 4'b0100; e.bool_op = 2'b11; end
            endcase
        end
        if (!ok) begin
            e.illegal = 1; e.rd_wen = 0; e.branch = 0; e.jump = 0; e.mem_rd = 0; e.mem_wr = 0;
        end
        if (e.rd == 5'd0) e.rd_wen = 1'b0;
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(m_valid));
        if (m_valid || m_full) begin
            chk({tag, ".o_pc"},      o_pc,              m_pc);
            chk({tag, ".o_illegal"}, 32'(o_illegal),    32'(m_exp.illegal));
            chk({tag, ".o_rd_wen"},  32'(o_rd_wen),     32'(m_exp.rd_wen));
            chk({tag, ".o_branch"},  32'(o_branch),     32'(m_exp.branch));
            chk({tag, ".o_jump"},    32'(o_jump),       32'(m_exp.jump));
            chk({tag, ".o_mem_rd"},  32'(o_mem_rd),     32'(m_exp.mem_rd));
            chk({tag, ".o_mem_wr"},  32'(o_mem_wr),     32'(m_exp.mem_wr));
            if (!m_exp.illegal) begin
                chk({tag, ".o_op_sel"},    32'(o_op_sel),    32'(m_exp.op_sel));
                chk({tag, ".o_sub"},       32'(o_sub),       32'(m_exp.sub));
                chk({tag, ".o_bool_op"},   32'(o_bool_op),   32'(m_exp.bool_op));
                chk({tag, ".o_shift_dir"}, 32'(o_shift_dir), 32'(m_exp.shift_dir));
                chk({tag, ".o_cmp_sig"},   32'(o_cmp_sig),   32'(m_exp.cmp_sig));
                chk({tag, ".o_a_sel"},     32'(o_a_sel),     32'(m_exp.a_sel));
                chk({tag, ".o_b_sel"},     32'(o_b_sel),     32'(m_exp.b_sel));
                chk({tag, ".o_imm"},       o_imm,            m_exp.imm);
                chk({tag, ".o_rs1"},       32'(o_rs1),       32'(m_exp.rs1));
                chk({tag, ".o_rs2"},       32'(o_rs2),       32'(m_exp.rs2));
                chk({tag, ".o_rd"},        32'(o_rd),        32'(m_exp.rd));
                chk({tag, ".o_br_cond"},   32'(o_br_cond),   32'(m_exp.br_cond));
            end
        end
    endtask

    // One clock: drive inputs, check o_ready, advance the expected state, check outputs.
    task automatic step(input string tag, input bit rst, input bit flush, input bit valid,
                        input bit ready, input logic [31:0] insn, input logic [31:0] pc,
                        input exp_t e);
        i_rst = rst; i_flush = flush; i_valid = valid; i_ready = ready;
        i_insn = insn; i_pc = pc;
        #1;
        if (!rst) chk({tag, ".o_ready"}, 32'(o_ready), 32'(!m_valid || ready));
        if (rst) begin
            m_valid = 1'b0; m_full = 1'b1; m_exp = '0; m_pc = RST_PC;
        end else if (flush) begin
            m_valid = 1'b0;
            m_full  = m_full && !m_valid;
        end else if (valid && (!m_valid || ready)) begin
            m_valid = 1'b1; m_full = 1'b1; m_exp = e; m_pc = pc;
        end else if (ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h03;
            8: w[6:0] = 7'h23;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    vec_t        tbl[14];
    exp_t        ea, eb;
    logic [31:0] w;

    initial begin
        tbl[0].insn  = 32'h00500093;  // ADDI x1,x0,5
        tbl[0].exp   = '{op_sel:4'b0001, b_sel:1'b1, imm:32'd5, rs2:5'd5, rd:5'd1, rd_wen:1'b1, default:'0};
        tbl[1].insn  = 32'h4030D113;  // SRAI x2,x1,3
        tbl[1].exp   = '{op_sel:4'b1000, sub:1'b1, shift_dir:1'b1, b_sel:1'b1, imm:32'd3,
                         rs1:5'd1, rs2:5'd3, rd:5'd2, rd_wen:1'b1, default:'0};
        tbl[2].insn  = 32'hFE20EEE3;  // BLTU x1,x2,-4
        tbl[2].exp   = '{op_sel:4'b0001, sub:1'b1, imm:32'hFFFF_FFFC, rs1:5'd1, rs2:5'd2,
                         rd:5'd29, branch:1'b1, br_cond:3'b110, default:'0};
        tbl[3].insn  = 32'h123452B7;  // LUI x5,0x12345
        tbl[3].exp   = '{op_sel:4'b0001, a_sel:2'b10, b_sel:1'b1, imm:32'h1234_5000,
                         rs1:5'd8, rs2:5'd3, rd:5'd5, rd_wen:1'b1, default:'0};
        tbl[4].insn  = 32'hFFFFFFFF;
        tbl[4].exp   = '{illegal:1'b1, default:'0};
        tbl[5].insn  = 32'h00100013;  // ADDI x0,x0,1
        tbl[5].exp   = '{op_sel:4'b0001, b_sel:1'b1, imm:32'd1, rs2:5'd1, default:'0};
        tbl[6].insn  = 32'h402081B3;  // SUB x3,x1,x2
        tbl[6].exp   = '{op_sel:4'b0001, sub:1'b1, rs1:5'd1, rs2:5'd2, rd:5'd3, rd_wen:1'b1, default:'0};
        tbl[7].insn  = 32'h0020F1B3;  // AND x3,x1,x2
        tbl[7].exp   = '{op_sel:4'b0100, bool_op:2'b11, rs1:5'd1, rs2:5'd2, rd:5'd3, rd_wen:1'b1, default:'0};
        tbl[8].insn  = 32'h008000EF;  // JAL x1,+8
        tbl[8].exp   = '{op_sel:4'b0001, a_sel:2'b01, b_sel:1'b1, imm:32'd8, rs2:5'd8, rd:5'd1,
                         jump:1'b1, rd_wen:1'b1, default:'0};
        tbl[9].insn  = 32'h0020A623;  // SW x2,12(x1)
        tbl[9].exp   = '{op_sel:4'b0001, b_sel:1'b1, imm:32'd12, rs1:5'd1, rs2:5'd2, rd:5'd12,
                         mem_wr:1'b1, default:'0};
        tbl[10].insn = 32'h4020C1B3;  // OP funct7=0100000 with xor: illegal
        tbl[10].exp  = '{illegal:1'b1, default:'0};
        tbl[11].insn = 32'h0020A063;  // BRANCH funct3=010: illegal
        tbl[11].exp  = '{illegal:1'b1, default:'0};
        tbl[12].insn = 32'h00009067;  // JALR funct3=001: illegal
        tbl[12].exp  = '{illegal:1'b1, default:'0};
        tbl[13].insn = 32'hFFF0B213;  // SLTIU x4,x1,-1
        tbl[13].exp  = '{op_sel:4'b0010, sub:1'b1, b_sel:1'b1, imm:32'hFFFF_FFFF, rs1:5'd1,
                         rs2:5'd31, rd:5'd4, rd_wen:1'b1, default:'0};

        step("reset", 1, 0, 0, 0, '0, '0, '0);
        step("reset", 1, 0, 1, 1, 32'h00500093, 32'h40, '0);

        foreach (tbl[i]) step($sformatf("vec%0d", i), 0, 0, 1, 1, tbl[i].insn, 32'h100 + 32'(i) * 4, tbl[i].exp);
        step("drain", 0, 0, 0, 1, '0, '0, '0);

        // Stall: A held for three cycles while B waits, then B transfers exactly once.
        ea = model(32'h00500093);
        eb = model(32'h4030D113);
        step("stall.a", 0, 0, 1, 1, 32'h00500093, 32'h200, ea);
        for (int k = 0; k < 3; k++) step("stall.hold", 0, 0, 1, 0, 32'h4030D113, 32'h204, eb);
        step("stall.b", 0, 0, 1, 1, 32'h4030D113, 32'h204, eb);
        step("stall.end", 0, 0, 0, 1, '0, '0, '0);

        // Flush during a stall drops both the held and the offered instruction.
        step("flush.a", 0, 0, 1, 1, 32'h00500093, 32'h300, ea);
        step("flush", 0, 1, 1, 0, 32'h4030D113, 32'h304, eb);
        step("flush.after", 0, 0, 0, 1, '0, '0, '0);

        // Reset mid-stream returns every output to its reset value.
        step("rst.a", 0, 0, 1, 1, 32'hFE20EEE3, 32'h400, model(32'hFE20EEE3));
        step("rst.mid", 1, 0, 1, 1, 32'h123452B7, 32'h404, model(32'h123452B7));
        step("rst.after", 0, 0, 0, 0, '0, '0, '0);

        for (int i = 0; i < 600; i++) begin
            w = rand_insn();
            step("rand", $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                 w, $urandom, model(w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
